match_event_logger: RTL and testbench

//   Downstream consumer of the pattern detector's MATCH pulse. Stamps each MATCH with a

---
 rtl/match_event_logger_if.sv | 13 +
 rtl/match_event_logger.sv | 117 +++++++++++
 tb/tb_match_event_logger.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/match_event_logger_if.sv
// Event drain bus of match_event_logger: head timestamp plus valid/ready handshake.
// A transfer happens on a CLK edge where EV_VALID and EV_READY are both 1; EV_VALID
// never depends on EV_READY, and EV_TS is only meaningful while EV_VALID is 1.
interface match_event_logger_if #(
    parameter int TS_W = 16
);
    logic [TS_W-1:0] EV_TS;
    logic            EV_VALID;
    logic            EV_READY;

    modport master (output EV_TS, output EV_VALID, input EV_READY);
    modport slave  (input EV_TS, input EV_VALID, output EV_READY);
endinterface

// File: rtl/match_event_logger.sv
// Timestamps single-cycle MATCH strobes and queues them in a first-word-fall-through FIFO.
// Optional macro MATCH_LOG_CNT_EN adds a saturating MATCH_TOTAL capture counter.
module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic                  EN,
    input  logic                  MATCH,
    match_event_logger_if.master  ev,
    output logic [AW:0]           FIFO_CNT,
    output logic                  OVF
`ifdef MATCH_LOG_CNT_EN
    ,
    output logic [15:0]           MATCH_TOTAL
`endif
);
    localparam logic [TS_W-1:0] TS_ONE   = 1;
    localparam logic [AW-1:0]   PTR_ONE  = 1;
    localparam logic [AW:0]     CNT_ONE  = 1;
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [TS_W-1:0] ts_q, ts_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [TS_W-1:0] mem_q [DEPTH];
    logic [TS_W-1:0] mem_d [DEPTH];

    logic push_req, pop, full, push;

    assign push_req = EN & MATCH;
    assign pop      = (cnt_q != '0) & ev.EV_READY;
    assign full     = (cnt_q == CNT_FULL);
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign push     = push_req & (~full | pop);

    always_comb begin
        ts_d     = ts_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        if (CLR) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (EN)
                ts_d = ts_q + TS_ONE;
            if (push) begin
                mem_d[wr_ptr_q] = ts_q;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)
                cnt_d = cnt_q + CNT_ONE;
            else if (pop && !push)
                cnt_d = cnt_q - CNT_ONE;
            if (push_req && full && !pop)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: '0};
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign ev.EV_TS    = mem_q[rd_ptr_q];
    assign ev.EV_VALID = (cnt_q != '0);
    assign FIFO_CNT    = cnt_q;
    assign OVF         = ovf_q;

`ifdef MATCH_LOG_CNT_EN
    logic [15:0] total_q, total_d;

    // Counts every accepted strobe, including those dropped on overflow.
    always_comb begin
        total_d = total_q;
        if (CLR)
            total_d = '0;
        else if (push_req && total_q != 16'hFFFF)
            total_d = total_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            total_q <= '0;
        else
            total_q <= total_d;
    end

    assign MATCH_TOTAL = total_q;
`endif
endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger: a TS_W=16 instance for most scenarios and a
// TS_W=4 instance for timestamp wrap.
module tb_match_event_logger;
    logic CLK = 1'b0;
    logic RST;

    logic       CLR, EN, MATCH;
    logic [3:0] cnt_a;
    logic       ovf_a;
    logic       CLR_b, EN_b, MATCH_b;
    logic [3:0] cnt_b;
    logic       ovf_b;
`ifdef MATCH_LOG_CNT_EN
    logic [15:0] tot_a, tot_b;
`endif

    int errors = 0;
    int checks = 0;

    match_event_logger_if #(.TS_W(16)) ev_a ();
    match_event_logger_if #(.TS_W(4))  ev_b ();

    match_event_logger #(.TS_W(16), .DEPTH(8), .AW(3)) dut_a (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .MATCH(MATCH),
        .ev(ev_a), .FIFO_CNT(cnt_a), .OVF(ovf_a)
`ifdef MATCH_LOG_CNT_EN
        , .MATCH_TOTAL(tot_a)
`endif
    );

    match_event_logger #(.TS_W(4), .DEPTH(8), .AW(3)) dut_b (
        .CLK(CLK), .RST(RST), .CLR(CLR_b), .EN(EN_b), .MATCH(MATCH_b),
        .ev(ev_b), .FIFO_CNT(cnt_b), .OVF(ovf_b)
`ifdef MATCH_LOG_CNT_EN
        , .MATCH_TOTAL(tot_b)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        CLR = 0; EN = 0; MATCH = 0; ev_a.EV_READY = 0;
        CLR_b = 0; EN_b = 0; MATCH_b = 0; ev_b.EV_READY = 0;
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ev_a.EV_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ev_a.EV_VALID); end
        checks++; if (ev_a.EV_TS !== 16'd0) begin errors++; $display("FAIL reset_ts got=%0d exp=0", ev_a.EV_TS); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf_a); end
    endtask

    // Single capture at ts=5, then one pop.
    task automatic test_single();
        do_reset();
        EN = 1;
        repeat (5) tick();
        MATCH = 1;
        tick();
        MATCH = 0;
        checks++; if (ev_a.EV_VALID !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", ev_a.EV_VALID); end
        checks++; if (ev_a.EV_TS !== 16'd5) begin errors++; $display("FAIL single_ts got=%0d exp=5", ev_a.EV_TS); end
        checks++; if (cnt_a !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", cnt_a); end
        ev_a.EV_READY = 1;
        tick();
        ev_a.EV_READY = 0;
        checks++; if (ev_a.EV_VALID !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%0b exp=0", ev_a.EV_VALID); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL single_pop_cnt got=%0d exp=0", cnt_a); end
    endtask

    // Nine strobes at ts=1..9 into an 8-deep FIFO; drain while EN=0.
    task automatic test_overflow();
        do_reset();
        EN = 1;
        tick();
        MATCH = 1;
        repeat (8) tick();
        checks++; if (cnt_a !== 4'd8) begin errors++; $display("FAIL ovf_fill_cnt got=%0d exp=8", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", ovf_a); end
        tick();
        MATCH = 0;
        EN = 0;
        checks++; if (cnt_a !== 4'd8) begin errors++; $display("FAIL ovf_full_cnt got=%0d exp=8", cnt_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", ovf_a); end
`ifdef MATCH_LOG_CNT_EN
        checks++; if (tot_a !== 16'd9) begin errors++; $display("FAIL total_after_ovf got=%0d exp=9", tot_a); end
`endif
        ev_a.EV_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (ev_a.EV_VALID !== 1'b1 || ev_a.EV_TS !== 16'(i)) begin
                errors++; $display("FAIL ovf_drain_%0d got valid=%0b ts=%0d exp valid=1 ts=%0d", i, ev_a.EV_VALID, ev_a.EV_TS, i);
            end
            tick();
        end
        ev_a.EV_READY = 0;
        checks++; if (ev_a.EV_VALID !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid got=%0b exp=0", ev_a.EV_VALID); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", ovf_a); end
    endtask

    // Full FIFO: capture and pop in the same edge.
    task automatic test_full_push_pop();
        do_reset();
        EN = 1;
        MATCH = 1;
        repeat (8) tick();
        MATCH = 0;
        repeat (12) tick();
        MATCH = 1;
        ev_a.EV_READY = 1;
        tick();
        MATCH = 0;
        EN = 0;
        ev_a.EV_READY = 0;
        checks++; if (cnt_a !== 4'd8) begin errors++; $display("FAIL fpp_cnt got=%0d exp=8", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%0b exp=0", ovf_a); end
        ev_a.EV_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            automatic logic [15:0] exp_ts = (i == 8) ? 16'd20 : 16'(i);
            checks++; if (ev_a.EV_VALID !== 1'b1 || ev_a.EV_TS !== exp_ts) begin
                errors++; $display("FAIL fpp_drain_%0d got valid=%0b ts=%0d exp valid=1 ts=%0d", i, ev_a.EV_VALID, ev_a.EV_TS, exp_ts);
            end
            tick();
        end
        ev_a.EV_READY = 0;
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL fpp_empty_cnt got=%0d exp=0", cnt_a); end
    endtask

    // TS_W=4: stamps 15 then 0 across the wrap; EN=0 blocks capture and freezes ts.
    task automatic test_ts_wrap();
        do_reset();
        EN_b = 1;
        repeat (15) tick();
        MATCH_b = 1;
        tick();
        tick();
        EN_b = 0;
        repeat (3) tick();
        checks++; if (cnt_b !== 4'd2) begin errors++; $display("FAIL wrap_en0_cnt got=%0d exp=2", cnt_b); end
        EN_b = 1;
        tick();
        EN_b = 0;
        MATCH_b = 0;
        ev_b.EV_READY = 1;
        for (int i = 0; i < 3; i++) begin
            automatic logic [3:0] exp_ts = (i == 0) ? 4'd15 : ((i == 1) ? 4'd0 : 4'd1);
            checks++; if (ev_b.EV_VALID !== 1'b1 || ev_b.EV_TS !== exp_ts) begin
                errors++; $display("FAIL wrap_drain_%0d got valid=%0b ts=%0d exp valid=1 ts=%0d", i, ev_b.EV_VALID, ev_b.EV_TS, exp_ts);
            end
            tick();
        end
        ev_b.EV_READY = 0;
        checks++; if (ev_b.EV_VALID !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%0b exp=0", ev_b.EV_VALID); end
    endtask

    // CLR with MATCH in the same cycle flushes everything; next stamp is 0.
    task automatic test_clear();
        do_reset();
        EN = 1;
        MATCH = 1;
        repeat (9) tick();
        MATCH = 0;
        EN = 0;
        ev_a.EV_READY = 1;
        repeat (5) tick();
        ev_a.EV_READY = 0;
        checks++; if (cnt_a !== 4'd3 || ovf_a !== 1'b1) begin errors++; $display("FAIL clr_pre got cnt=%0d ovf=%0b exp cnt=3 ovf=1", cnt_a, ovf_a); end
        CLR = 1; EN = 1; MATCH = 1; ev_a.EV_READY = 1;
        tick();
        CLR = 0; ev_a.EV_READY = 0;
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", cnt_a); end
        checks++; if (ev_a.EV_VALID !== 1'b0) begin errors++; $display("FAIL clr_valid got=%0b exp=0", ev_a.EV_VALID); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%0b exp=0", ovf_a); end
        tick();
        MATCH = 0;
        EN = 0;
        checks++; if (ev_a.EV_VALID !== 1'b1 || ev_a.EV_TS !== 16'd0 || cnt_a !== 4'd1) begin
            errors++; $display("FAIL clr_restamp got valid=%0b ts=%0d cnt=%0d exp valid=1 ts=0 cnt=1", ev_a.EV_VALID, ev_a.EV_TS, cnt_a);
        end
`ifdef MATCH_LOG_CNT_EN
        checks++; if (tot_a !== 16'd1) begin errors++; $display("FAIL clr_total got=%0d exp=1", tot_a); end
`endif
    endtask

    // RST raised between edges clears outputs without waiting for a clock edge.
    task automatic test_async_reset();
        do_reset();
        EN = 1;
        MATCH = 1;
        repeat (9) tick();
        MATCH = 0;
        EN = 0;
        ev_a.EV_READY = 1;
        repeat (2) tick();
        checks++; if (cnt_a !== 4'd6 || ovf_a !== 1'b1) begin errors++; $display("FAIL arst_pre got cnt=%0d ovf=%0b exp cnt=6 ovf=1", cnt_a, ovf_a); end
        #2;
        RST = 1;
        #1;
        checks++; if (ev_a.EV_VALID !== 1'b0 || cnt_a !== 4'd0 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL arst_clear got valid=%0b cnt=%0d ovf=%0b exp 0 0 0", ev_a.EV_VALID, cnt_a, ovf_a);
        end
        ev_a.EV_READY = 0;
        tick();
        RST = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_ts_wrap();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
